hs32_decode_q: RTL and testbench
================================

Name: hs32_decode_q

Overview:
- Parametrised, fully handshaked successor to the HS32 decode stage, sitting between fetch and execute.
- Accepts 32-bit instruction words from fetch on a valid/ready handshake.
- Splits each word into register, ALU, shift, immediate and control fields, and flags illegal encodings.
- Queues the decoded packets in a DEPTH-entry FIFO so execute back-pressure never drops or corrupts an instruction; a flush discards all queued packets on branch/exception.

Parameters:
- IMM_W, 32, width of the `imm` output; must be ≥ 24.
- SEXT_IMM, 1, 1 = sign-extend imm16/imm24 to IMM_W; 0 = zero-extend.
- DEPTH, 2, number of decoded-packet entries in the output queue; power of 2, ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued packets and any input presented this cycle.
- instd  in  32  instruction word from fetch.
- in_valid  in  1  instd valid.
- in_ready  out  1  decoder can accept instd this cycle.
- out_valid  out  1  head packet valid to execute.
- out_ready  in  1  execute consumes head packet.
- fmt  out  3  format: 0 illegal, 1 reg/shift, 2 imm16, 3 imm24, 4 jump.
- aluop  out  4  ALU operation.
- regdst  out  4  Rd.
- regsrc  out  4  Rm.
- regopd  out  4  Rn.
- shift  out  5  shift amount.
- imm  out  IMM_W  extended immediate.
- ctlsig  out  7  control/condition bits.
- illegal  out  1  head packet is an illegal encoding.
- count  out  $clog2(DEPTH)+1  queued packet count.

Behaviour:
- Reset value of every output and of internal state is 0, including in_ready. In the first cycle after reset deasserts, in_ready becomes 1.
- The queue is empty after reset and holds no valid entries.
- Decode is purely on instd[31:28]:
  - 4'h1 reg/shift: aluop=[27:24], regdst=[23:20], regsrc=[19:16], regopd=[15:12], shift=[11:7], ctlsig=[6:0], imm=0.
  - 4'h2 imm16: aluop=[27:24], regdst=[23:20], regsrc=[19:16], imm=ext([15:0]).
  - 4'h3 imm24: ctlsig={3'b0,[27:24]}, imm=ext([23:0]).
  - 4'h4 jump: ctlsig={3'b0,[27:24]}, regdst=[23:20], aluop=[19:16], imm=ext([15:0]).
  - Any other prefix: fmt=0, illegal=1, all other fields 0. The illegal packet is still queued so execute can raise the trap in order.
- Fields not listed for a format are driven 0.
- Push occurs when in_valid && in_ready && !flush. Pop occurs when out_valid && out_ready && !flush.
- in_ready is registered: 1 iff the next-cycle count < DEPTH. There is no combinational path from out_ready to in_ready.
- Latency: a word pushed in cycle N into an empty queue appears with out_valid=1 in cycle N+1. There is no combinational input-to-output path.
- Push and pop in the same cycle: count unchanged, FIFO order preserved. This is legal when full provided in_ready was 1.
- Full (count==DEPTH): in_ready=0, and in_valid is ignored.
- Empty: out_valid=0. Output fields hold their last values and are don't-care.
- Pointers wrap modulo DEPTH.
- flush has priority over push and pop. In the next cycle count=0 and out_valid=0, and in_ready=1 from the next cycle.
- reset has priority over flush. Reset mid-stream discards all entries.
- Output fields are registered views of the head entry and are stable while out_valid && !out_ready.

Test Plan:
- Imm16 decode: instd=0x2A358001, SEXT_IMM=1 -> next cycle out_valid=1, fmt=2, aluop=0xA, regdst=3, regsrc=5, imm=0xFFFF8001. With SEXT_IMM=0 -> imm=0x00008001.
- Reg/shift decode: instd=0x12123F85 -> fmt=1, aluop=2, regdst=1, regsrc=2, regopd=3, shift=0x1F, ctlsig=0x05, imm=0.
- Imm24 decode and illegal: instd=0x3E800000 -> fmt=3, ctlsig=0x0E, imm=0xFF800000. Then instd=0xF0000000 -> fmt=0, illegal=1, in order behind the first packet.
- Back-pressure (DEPTH=2): hold out_ready=0 and push 3 words -> in_ready=0 after 2 pushes and count=2. The third word stays pending. Release out_ready -> all 3 words emerge in order, none lost or duplicated.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, and output sequence equals input sequence.
- Flush with count=2 and in_valid=1 -> next cycle count=0 and out_valid=0. The flushed-cycle input never appears at the output. Assert reset during streaming -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hs32_decode_q.sv
// hs32_decode_q: HS32 decode stage with a decoded-packet output queue.
//
// Purpose:
//   Accepts 32-bit instruction words from fetch (valid/ready), splits them
//   into register/ALU/shift/immediate/control fields, flags illegal prefixes,
//   and queues the decoded packets in a DEPTH-entry FIFO toward execute.
//   A flush discards every queued packet and any word offered that cycle.
//
// Parameters:
//   IMM_W    width of imm (>= 24)
//   SEXT_IMM 1 = sign-extend imm16/imm24, 0 = zero-extend
//   DEPTH    queue entries (power of 2, >= 1)
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                drop queue contents and this cycle's input
//   instd, in_valid      instruction word from fetch and its valid
//   in_ready             registered: queue can take a word this cycle
//   out_valid, out_ready head packet valid / consumed by execute
//   fmt .. illegal       registered view of the head packet
//   count                number of queued packets
module hs32_decode_q #(
  parameter int IMM_W    = 32,
  parameter bit SEXT_IMM = 1'b1,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [31:0]              instd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               fmt,
  output logic [3:0]               aluop,
  output logic [3:0]               regdst,
  output logic [3:0]               regsrc,
  output logic [3:0]               regopd,
  output logic [4:0]               shift,
  output logic [IMM_W-1:0]         imm,
  output logic [6:0]               ctlsig,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    FMT_ILLEGAL = 3'd0,
    FMT_REG     = 3'd1,
    FMT_IMM16   = 3'd2,
    FMT_IMM24   = 3'd3,
    FMT_JUMP    = 3'd4
  } fmt_e;

  typedef struct packed {
    fmt_e             fmt;
    logic [3:0]       aluop;
    logic [3:0]       regdst;
    logic [3:0]       regsrc;
    logic [3:0]       regopd;
    logic [4:0]       shift;
    logic [IMM_W-1:0] imm;
    logic [6:0]       ctlsig;
    logic             illegal;
  } pkt_t;

  pkt_t             r_mem [DEPTH];
  pkt_t             r_head;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_in_ready;

  pkt_t             w_dec;
  pkt_t             w_head_nxt;
  logic [IMM_W-1:0] w_imm16;
  logic [IMM_W-1:0] w_imm24;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_after_pop;
  logic [CW-1:0]    w_cnt_nxt;
  logic [PW-1:0]    w_rd_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_imm16 = SEXT_IMM ? {{(IMM_W-16){instd[15]}}, instd[15:0]}
                            : {{(IMM_W-16){1'b0}}, instd[15:0]};
  assign w_imm24 = SEXT_IMM ? {{(IMM_W-24){instd[23]}}, instd[23:0]}
                            : {{(IMM_W-24){1'b0}}, instd[23:0]};

  always_comb begin
    w_dec = '0;
    case (instd[31:28])
      4'h1: begin
        w_dec.fmt    = FMT_REG;
        w_dec.aluop  = instd[27:24];
        w_dec.regdst = instd[23:20];
        w_dec.regsrc = instd[19:16];
        w_dec.regopd = instd[15:12];
        w_dec.shift  = instd[11:7];
        w_dec.ctlsig = instd[6:0];
      end
      4'h2: begin
        w_dec.fmt    = FMT_IMM16;
        w_dec.aluop  = instd[27:24];
        w_dec.regdst = instd[23:20];
        w_dec.regsrc = instd[19:16];
        w_dec.imm    = w_imm16;
      end
      4'h3: begin
        w_dec.fmt    = FMT_IMM24;
        w_dec.ctlsig = {3'b000, instd[27:24]};
        w_dec.imm    = w_imm24;
      end
      4'h4: begin
        w_dec.fmt    = FMT_JUMP;
        w_dec.ctlsig = {3'b000, instd[27:24]};
        w_dec.regdst = instd[23:20];
        w_dec.aluop  = instd[19:16];
        w_dec.imm    = w_imm16;
      end
      default: begin
        w_dec.fmt     = FMT_ILLEGAL;
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  assign w_push      = in_valid && r_in_ready && !flush;
  assign w_pop       = (r_count != '0) && out_ready && !flush;
  assign w_after_pop = r_count - CW'(w_pop);
  assign w_cnt_nxt   = flush ? '0 : w_after_pop + CW'(w_push);
  assign w_rd_nxt    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;

  // The head register is loaded one cycle ahead. When the word being pushed
  // becomes the head (queue empty after this cycle's pop) it has not been
  // written to r_mem yet, so it is bypassed straight from the decoder.
  always_comb begin
    w_head_nxt = r_mem[w_rd_nxt];
    if (w_push && (w_after_pop == '0)) begin
      w_head_nxt = w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b0;
      r_head     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count    <= w_cnt_nxt;
      r_in_ready <= (w_cnt_nxt < CW'(DEPTH));
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_dec;
          r_wr_ptr        <= ptr_inc(r_wr_ptr);
        end
        r_rd_ptr <= w_rd_nxt;
        // Head holds its last value once the queue drains.
        if (w_cnt_nxt != '0) begin
          r_head <= w_head_nxt;
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_count != '0);
  assign count     = r_count;
  assign fmt       = r_head.fmt;
  assign aluop     = r_head.aluop;
  assign regdst    = r_head.regdst;
  assign regsrc    = r_head.regsrc;
  assign regopd    = r_head.regopd;
  assign shift     = r_head.shift;
  assign imm       = r_head.imm;
  assign ctlsig    = r_head.ctlsig;
  assign illegal   = r_head.illegal;

endmodule

// File: tb/tb_hs32_decode_q.sv
module tb_hs32_decode_q;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] instd;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, illegal;
  logic [2:0]  fmt;
  logic [3:0]  aluop, regdst, regsrc, regopd;
  logic [4:0]  shift;
  logic [31:0] imm;
  logic [6:0]  ctlsig;
  logic [1:0]  count;

  logic        z_in_ready, z_out_valid, z_illegal;
  logic [2:0]  z_fmt;
  logic [3:0]  z_aluop, z_regdst, z_regsrc, z_regopd;
  logic [4:0]  z_shift;
  logic [31:0] z_imm;
  logic [6:0]  z_ctlsig;
  logic [1:0]  z_count;

  int checks = 0;
  int errors = 0;

  hs32_decode_q #(.IMM_W(32), .SEXT_IMM(1'b1), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instd(instd),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .fmt(fmt), .aluop(aluop), .regdst(regdst),
    .regsrc(regsrc), .regopd(regopd), .shift(shift), .imm(imm),
    .ctlsig(ctlsig), .illegal(illegal), .count(count)
  );

  hs32_decode_q #(.IMM_W(32), .SEXT_IMM(1'b0), .DEPTH(2)) dut_z (
    .clk(clk), .reset(reset), .flush(flush), .instd(instd),
    .in_valid(in_valid), .in_ready(z_in_ready), .out_valid(z_out_valid),
    .out_ready(out_ready), .fmt(z_fmt), .aluop(z_aluop), .regdst(z_regdst),
    .regsrc(z_regsrc), .regopd(z_regopd), .shift(z_shift), .imm(z_imm),
    .ctlsig(z_ctlsig), .illegal(z_illegal), .count(z_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'h0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'h0);
    check({tag, ".count"},     32'(count),     32'h0);
    check({tag, ".fmt"},       32'(fmt),       32'h0);
    check({tag, ".aluop"},     32'(aluop),     32'h0);
    check({tag, ".regdst"},    32'(regdst),    32'h0);
    check({tag, ".regsrc"},    32'(regsrc),    32'h0);
    check({tag, ".regopd"},    32'(regopd),    32'h0);
    check({tag, ".shift"},     32'(shift),     32'h0);
    check({tag, ".imm"},       imm,            32'h0);
    check({tag, ".ctlsig"},    32'(ctlsig),    32'h0);
    check({tag, ".illegal"},   32'(illegal),   32'h0);
  endtask

  typedef struct {
    logic [31:0] instd;
    logic [2:0]  fmt;
    logic [3:0]  aluop;
    logic [3:0]  regdst;
    logic [3:0]  regsrc;
    logic [3:0]  regopd;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic [31:0] immz;
    logic [6:0]  ctl;
    logic        ill;
  } vec_t;

  vec_t vt [10];

  initial begin
    //        instd         fmt   alu   rd    rs    rn    sh     imm(sext)     imm(zext)     ctl    ill
    vt[0] = '{32'h2A358001, 3'd2, 4'hA, 4'h3, 4'h5, 4'h0, 5'h00, 32'hFFFF8001, 32'h00008001, 7'h00, 1'b0};
    vt[1] = '{32'h12123F85, 3'd1, 4'h2, 4'h1, 4'h2, 4'h3, 5'h1F, 32'h00000000, 32'h00000000, 7'h05, 1'b0};
    vt[2] = '{32'h3E800000, 3'd3, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 32'hFF800000, 32'h00800000, 7'h0E, 1'b0};
    vt[3] = '{32'hF0000000, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 32'h00000000, 32'h00000000, 7'h00, 1'b1};
    vt[4] = '{32'h4C7A1234, 3'd4, 4'hA, 4'h7, 4'h0, 4'h0, 5'h00, 32'h00001234, 32'h00001234, 7'h0C, 1'b0};
    vt[5] = '{32'h4512ABCD, 3'd4, 4'h2, 4'h1, 4'h0, 4'h0, 5'h00, 32'hFFFFABCD, 32'h0000ABCD, 7'h05, 1'b0};
    vt[6] = '{32'h0FFFFFFF, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 32'h00000000, 32'h00000000, 7'h00, 1'b1};
    vt[7] = '{32'h20007FFF, 3'd2, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 32'h00007FFF, 32'h00007FFF, 7'h00, 1'b0};
    vt[8] = '{32'h317FFFFF, 3'd3, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 32'h007FFFFF, 32'h007FFFFF, 7'h01, 1'b0};
    vt[9] = '{32'h5ABCDEF0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 5'h00, 32'h00000000, 32'h00000000, 7'h00, 1'b1};

    reset = 1'b1; flush = 1'b0; instd = '0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    check_all_zero("reset");

    reset = 1'b0;
    step();
    check("post_reset.in_ready",  32'(in_ready),  32'h1);
    check("post_reset.out_valid", 32'(out_valid), 32'h0);
    check("post_reset.count",     32'(count),     32'h0);

    // Table-driven decode: push one word, check it one cycle later, drain.
    for (int i = 0; i < 10; i++) begin
      instd = vt[i].instd; in_valid = 1'b1; out_ready = 1'b0;
      step();
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("v%0d.count", i),     32'(count),     32'h1);
      check($sformatf("v%0d.fmt", i),       32'(fmt),       32'(vt[i].fmt));
      check($sformatf("v%0d.aluop", i),     32'(aluop),     32'(vt[i].aluop));
      check($sformatf("v%0d.regdst", i),    32'(regdst),    32'(vt[i].regdst));
      check($sformatf("v%0d.regsrc", i),    32'(regsrc),    32'(vt[i].regsrc));
      check($sformatf("v%0d.regopd", i),    32'(regopd),    32'(vt[i].regopd));
      check($sformatf("v%0d.shift", i),     32'(shift),     32'(vt[i].shift));
      check($sformatf("v%0d.imm", i),       imm,            vt[i].imm);
      check($sformatf("v%0d.imm_zext", i),  z_imm,          vt[i].immz);
      check($sformatf("v%0d.ctlsig", i),    32'(ctlsig),    32'(vt[i].ctl));
      check($sformatf("v%0d.illegal", i),   32'(illegal),   32'(vt[i].ill));
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      check($sformatf("v%0d.drained", i),   32'(out_valid), 32'h0);
    end

    // Back-pressure: three words with execute stalled, then release.
    out_ready = 1'b0; in_valid = 1'b1; instd = 32'h3E800000;
    step();
    check("bp1.count",    32'(count),    32'h1);
    check("bp1.in_ready", 32'(in_ready), 32'h1);
    check("bp1.fmt",      32'(fmt),      32'h3);
    instd = 32'hF0000000;
    step();
    check("bp2.count",    32'(count),    32'h2);
    check("bp2.in_ready", 32'(in_ready), 32'h0);
    check("bp2.fmt",      32'(fmt),      32'h3);
    instd = 32'h12123F85;
    step();
    check("bp3.count",    32'(count),    32'h2);
    check("bp3.in_ready", 32'(in_ready), 32'h0);
    check("bp3.fmt",      32'(fmt),      32'h3);
    check("bp3.ctlsig",   32'(ctlsig),   32'h0E);
    check("bp3.imm",      imm,           32'hFF800000);
    out_ready = 1'b1;
    step();
    check("bp4.count",    32'(count),    32'h1);
    check("bp4.in_ready", 32'(in_ready), 32'h1);
    check("bp4.fmt",      32'(fmt),      32'h0);
    check("bp4.illegal",  32'(illegal),  32'h1);
    step();
    check("bp5.count",    32'(count),    32'h1);
    check("bp5.fmt",      32'(fmt),      32'h1);
    check("bp5.shift",    32'(shift),    32'h1F);
    check("bp5.illegal",  32'(illegal),  32'h0);
    in_valid = 1'b0;
    step();
    check("bp6.out_valid", 32'(out_valid), 32'h0);
    check("bp6.count",     32'(count),     32'h0);

    // Simultaneous push and pop at count==1.
    out_ready = 1'b0; in_valid = 1'b1; instd = 32'h2F000000;
    step();
    check("pp0.count", 32'(count), 32'h1);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      instd = 32'h20000000 | (32'(k) << 20) | 32'(k * 3);
      step();
      check($sformatf("pp%0d.count", k + 1),  32'(count),  32'h1);
      check($sformatf("pp%0d.regdst", k + 1), 32'(regdst), 32'(k));
      check($sformatf("pp%0d.imm", k + 1),    imm,         32'(k * 3));
    end
    in_valid = 1'b0;
    step();
    check("pp_end.count", 32'(count), 32'h0);

    // Flush with one entry queued and a word accepted in the flush cycle.
    out_ready = 1'b0; in_valid = 1'b1; instd = 32'h12123F85;
    step();
    flush = 1'b1; instd = 32'h4C7A1234;
    step();
    check("fl1.count",     32'(count),     32'h0);
    check("fl1.out_valid", 32'(out_valid), 32'h0);
    check("fl1.in_ready",  32'(in_ready),  32'h1);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("fl1_after.out_valid", 32'(out_valid), 32'h0);

    // Flush when full with in_valid held high.
    in_valid = 1'b1; instd = 32'h2A358001;
    step();
    instd = 32'h3E800000;
    step();
    check("fl2_pre.count", 32'(count), 32'h2);
    flush = 1'b1; instd = 32'h4512ABCD;
    step();
    check("fl2.count",     32'(count),     32'h0);
    check("fl2.out_valid", 32'(out_valid), 32'h0);
    check("fl2.in_ready",  32'(in_ready),  32'h1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("fl2_after.out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b1; instd = 32'h4C7A1234;
    step();
    check("fl2_new.fmt",    32'(fmt),    32'h4);
    check("fl2_new.regdst", 32'(regdst), 32'h7);
    in_valid = 1'b0;
    step();

    // Reset while streaming.
    out_ready = 1'b0; in_valid = 1'b1; instd = 32'h12123F85;
    step();
    instd = 32'h2A358001;
    step();
    check("rs_pre.count", 32'(count), 32'h2);
    reset = 1'b1; out_ready = 1'b1;
    step();
    check_all_zero("rs_mid");
    reset = 1'b0; in_valid = 1'b0;
    step();
    check("rs_after.in_ready",  32'(in_ready),  32'h1);
    check("rs_after.out_valid", 32'(out_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
